// File: rtl/picomips_pkg.sv
// Shared opcode, ALU and state encodings for the picoMIPS control path,
// plus the single-cycle decode table used by the control FSM.
package picomips_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        ADD   = 3'd1,
        MULT  = 3'd2,
        ADDI  = 3'd3,
        SUBI  = 3'd4,
        MULTI = 3'd5,
        WLD0  = 3'd6,
        WLD1  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MUL  = 2'd2,
        ALU_PASS = 2'd3
    } alu_t;

    typedef enum logic [1:0] {
        EXEC      = 2'd0,
        MULT_WAIT = 2'd1,
        WAIT_HI   = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    typedef struct packed {
        alu_t alu;
        logic imm;
        logic w;
    } decode_t;

    // Datapath controls for an opcode once it completes; NOP writes nothing.
    function automatic decode_t decode(opcode_t op);
        decode_t d;
        d = '{alu: ALU_ADD, imm: 1'b0, w: 1'b1};
        case (op)
            NOP:   d.w   = 1'b0;
            ADDI:  d.imm = 1'b1;
            SUBI:  d     = '{alu: ALU_SUB, imm: 1'b1, w: 1'b1};
            MULT:  d.alu = ALU_MUL;
            MULTI: d     = '{alu: ALU_MUL, imm: 1'b1, w: 1'b1};
            WLD0,
            WLD1:  d.alu = ALU_PASS;
            default: d   = d;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hs_debouncer.sv
// Synchroniser plus stability counter for the raw handshake switch; the
// debounced level only moves after DEBOUNCE_CYCLES consecutive differing samples.
module hs_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic raw,
    output logic debounced
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the shift chain does not collapse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            debounced <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (synced == debounced) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q     <= '0;
                debounced <= synced;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/picomips_control_fsm.sv
// picoMIPS instruction control: Mealy decode of the opcode with stalls for
// multi-cycle multiply and for the debounced handshake switch (WLD0/WLD1).
module picomips_control_fsm
    import picomips_pkg::*;
#(
    parameter int OPCODE_SIZE     = 3,
    parameter int ALU_FUNC_SIZE   = 2,
    parameter int MULT_CYCLES     = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic [OPCODE_SIZE-1:0]   opcode,
    input  logic                     handshake_switch,
    output logic                     pc_inc,
    output logic [ALU_FUNC_SIZE-1:0] alu_func,
    output logic                     imm,
    output logic                     w,
    output logic                     busy,
    output logic                     illegal
);

    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);

    state_t           state_q, state_d;
    opcode_t          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    opcode_t          live_op, cur_op;
    decode_t          dec;
    logic             debounced, illegal_op;
    logic             pc_inc_c, w_c, illegal_c;

    hs_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .n_reset  (n_reset),
        .raw      (handshake_switch),
        .debounced(debounced)
    );

    if (OPCODE_SIZE > 3) begin : g_wide_opcode
        assign illegal_op = |opcode[OPCODE_SIZE-1:3];
    end else begin : g_narrow_opcode
        assign illegal_op = 1'b0;
    end

    assign live_op = opcode_t'(opcode[2:0]);
    // Wait states run off the latched opcode so the fetch side may move on.
    assign cur_op  = (state_q == EXEC) ? live_op : op_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= EXEC;
            op_q    <= NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        pc_inc_c  = 1'b0;
        w_c       = 1'b0;
        illegal_c = 1'b0;
        dec       = decode(cur_op);

        case (state_q)
            EXEC: begin
                if (illegal_op) begin
                    dec       = decode(NOP);
                    pc_inc_c  = 1'b1;
                    illegal_c = 1'b1;
                end else begin
                    case (live_op)
                        MULT, MULTI: begin
                            if (MULT_CYCLES == 1) begin
                                pc_inc_c = 1'b1;
                                w_c      = 1'b1;
                            end else begin
                                op_d    = live_op;
                                cnt_d   = CNT_W'(1);
                                state_d = MULT_WAIT;
                            end
                        end
                        WLD1: begin
                            if (debounced) begin
                                pc_inc_c = 1'b1;
                                w_c      = 1'b1;
                            end else begin
                                op_d    = live_op;
                                state_d = WAIT_HI;
                            end
                        end
                        WLD0: begin
                            if (!debounced) begin
                                pc_inc_c = 1'b1;
                                w_c      = 1'b1;
                            end else begin
                                op_d    = live_op;
                                state_d = WAIT_LO;
                            end
                        end
                        default: begin
                            pc_inc_c = 1'b1;
                            w_c      = dec.w;
                        end
                    endcase
                end
            end
            MULT_WAIT: begin
                if (cnt_q == MULT_LAST) begin
                    pc_inc_c = 1'b1;
                    w_c      = 1'b1;
                    cnt_d    = '0;
                    state_d  = EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (debounced) begin
                    pc_inc_c = 1'b1;
                    w_c      = 1'b1;
                    state_d  = EXEC;
                end
            end
            WAIT_LO: begin
                if (!debounced) begin
                    pc_inc_c = 1'b1;
                    w_c      = 1'b1;
                    state_d  = EXEC;
                end
            end
            default: state_d = EXEC;
        endcase
    end

    // Reset asserted gates every output to zero without waiting for a clock.
    assign pc_inc   = n_reset & pc_inc_c;
    assign w        = n_reset & w_c;
    assign busy     = n_reset & ~pc_inc_c;
    assign illegal  = n_reset & illegal_c;
    assign imm      = n_reset & dec.imm;
    assign alu_func = n_reset ? ALU_FUNC_SIZE'(dec.alu) : '0;

endmodule
